// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared helpers for the pipelined adder/subtractor.
// Provides the stage-count computation, the slice index helper and the
// operation descriptor used to form the effective carry.
package adder_pipe_pkg;

    typedef struct packed {
        logic sub;
        logic carry_in;
    } op_t;

    // Number of CHUNK-bit slices in a WIDTH-bit word; 0 flags an illegal pairing
    function automatic int calc_stages(input int width, input int chunk);
        if (chunk < 1) begin
            return 0;
        end
        if (width < chunk) begin
            return 0;
        end
        if ((width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

    // Bit index of the lowest bit of slice k
    function automatic int slice_lo(input int k, input int chunk);
        return k * chunk;
    endfunction

    // Subtraction is a + ~b + 1, so the incoming carry/borrow is inverted for sub
    function automatic logic eff_carry(input op_t op);
        return op.carry_in ^ op.sub;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operation/result handshake bundle of adder_pipe.
// The master side presents operations and consumes results; the slave
// side is the adder itself.
interface adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, operand1, operand2, carry_in, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, operand1, operand2, carry_in, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: one CHUNK-bit slice of the pipelined carry chain.
// Adds its operand slices plus the incoming carry and registers the slice
// sum, the carry out and the stage valid bit; holds while en is low.
module adder_pipe_stage
    import adder_pipe_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             vld_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic             vld_o,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o
);
    logic [CHUNK:0]   add_w;
    logic             vld_d;
    logic             vld_q;
    logic [CHUNK-1:0] sum_d;
    logic [CHUNK-1:0] sum_q;
    logic             c_d;
    logic             c_q;

    // Slice addition; the stage keeps its contents while the pipeline is stalled
    always_comb begin
        add_w = {1'b0, a_i} + {1'b0, b_i} + (CHUNK + 1)'(c_i);
        vld_d = vld_q;
        sum_d = sum_q;
        c_d   = c_q;
        if (en) begin
            vld_d = vld_i;
            sum_d = add_w[CHUNK-1:0];
            c_d   = add_w[CHUNK];
        end
    end

    // Stage register; reset empties the stage and clears its data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            sum_q <= '0;
            c_q   <= 1'b0;
        end else begin
            vld_q <= vld_d;
            sum_q <= sum_d;
            c_q   <= c_d;
        end
    end

    assign vld_o = vld_q;
    assign sum_o = sum_q;
    assign c_o   = c_q;

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit adder/subtractor, one CHUNK-bit carry
// slice per stage, valid/ready on both sides with full backpressure.
// Optional build macro ADDER_PIPE_FLAGS_EN adds registered overflow, zero
// and negative flags; without it those outputs are tied low.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (STAGES < 1) begin : g_param_check
        $error("adder_pipe: WIDTH must be a positive multiple of CHUNK and CHUNK >= 1");
    end

    logic             adv;
    logic             out_vld;
    logic             c_eff;
    logic [WIDTH-1:0] b_eff;
    op_t              op;

    // Form effective operands and the single advance enable shared by every stage
    always_comb begin
        op    = '{sub: bus.sub, carry_in: bus.carry_in};
        c_eff = eff_carry(op);
        b_eff = op.sub ? ~bus.operand2 : bus.operand2;
        adv   = !out_vld || bus.out_ready;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - slice_lo(k, CHUNK);

        // a_src/b_src hold the not-yet-added slices, current slice at bit 0
        logic [SRC_W-1:0]       a_src;
        logic [SRC_W-1:0]       b_src;
        logic                   c_in;
        logic                   vld_in;
        logic [CHUNK-1:0]       sum;
        logic                   c_out;
        logic                   vld;
        logic [(k+1)*CHUNK-1:0] res_w;

        if (k == 0) begin : g_head
            assign a_src  = bus.operand1;
            assign b_src  = b_eff;
            assign c_in   = c_eff;
            assign vld_in = bus.in_valid;
            assign res_w  = sum;
        end else begin : g_body
            logic [k*CHUNK-1:0] lo_d;
            logic [k*CHUNK-1:0] lo_q;

            assign a_src  = g_stage[k-1].g_skew.a_rem_q;
            assign b_src  = g_stage[k-1].g_skew.b_rem_q;
            assign c_in   = g_stage[k-1].c_out;
            assign vld_in = g_stage[k-1].vld;
            assign res_w  = {sum, lo_q};

            // Finished low result slices ride alongside the slice being added
            always_comb lo_d = adv ? g_stage[k-1].res_w : lo_q;

            // Deskew register for the completed low slices
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_q <= '0;
                end else begin
                    lo_q <= lo_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [SRC_W-CHUNK-1:0] a_rem_d;
            logic [SRC_W-CHUNK-1:0] a_rem_q;
            logic [SRC_W-CHUNK-1:0] b_rem_d;
            logic [SRC_W-CHUNK-1:0] b_rem_q;

            // Upper slices not yet added move one stage on, realigned to bit 0
            always_comb begin
                a_rem_d = adv ? a_src[SRC_W-1:CHUNK] : a_rem_q;
                b_rem_d = adv ? b_src[SRC_W-1:CHUNK] : b_rem_q;
            end

            // Skew register for the pending operand slices
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        adder_pipe_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .vld_i (vld_in),
            .a_i   (a_src[CHUNK-1:0]),
            .b_i   (b_src[CHUNK-1:0]),
            .c_i   (c_in),
            .vld_o (vld),
            .sum_o (sum),
            .c_o   (c_out)
        );

`ifdef ADDER_PIPE_FLAGS_EN
        if (k == STAGES - 1) begin : g_flags
            logic [CHUNK-1:0] top_sum;
            logic             lo_zero;
            logic             ovf_d;
            logic             ovf_q;
            logic             zero_d;
            logic             zero_q;
            logic             neg_d;
            logic             neg_q;

            if (k == 0) begin : g_lo_none
                assign lo_zero = 1'b1;
            end else begin : g_lo_any
                assign lo_zero = ~|g_stage[k-1].res_w;
            end

            // MSB slice sum re-derived so the flags register together with the result
            always_comb begin
                top_sum = a_src[CHUNK-1:0] + b_src[CHUNK-1:0] + CHUNK'(c_in);
                ovf_d   = ovf_q;
                zero_d  = zero_q;
                neg_d   = neg_q;
                if (adv) begin
                    neg_d  = top_sum[CHUNK-1];
                    ovf_d  = (a_src[CHUNK-1] == b_src[CHUNK-1]) &&
                             (top_sum[CHUNK-1] != a_src[CHUNK-1]);
                    zero_d = lo_zero && (top_sum == '0);
                end
            end

            // Flag registers aligned with the final stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                    neg_q  <= neg_d;
                end
            end
        end
`endif
    end

    assign out_vld       = g_stage[STAGES-1].vld;
    assign bus.out_valid = out_vld;
    assign bus.in_ready  = adv;
    assign bus.result    = g_stage[STAGES-1].res_w;
    assign bus.carry_out = g_stage[STAGES-1].c_out;

`ifdef ADDER_PIPE_FLAGS_EN
    assign bus.overflow  = g_stage[STAGES-1].g_flags.ovf_q;
    assign bus.zero      = g_stage[STAGES-1].g_flags.zero_q;
    assign bus.negative  = g_stage[STAGES-1].g_flags.neg_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.zero      = 1'b0;
    assign bus.negative  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: self-checking bench for adder_pipe (WIDTH=32, CHUNK=8).
// Expected results come from an integer-arithmetic model and a FIFO of
// accepted operations; ADDER_PIPE_FLAGS_EN selects the flag expectations.
module tb_adder_pipe;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = 4;
`ifdef ADDER_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    adder_pipe #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_q[$];

    // Packed {result, carry_out, overflow, zero, negative} from plain integer arithmetic
    function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub);
        longint      ua, ub, sa, sb, ci, ur, sr;
        logic [31:0] r;
        logic        co, ovf;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        ci = cin;
        if (sub) begin
            ur = ua - ub - ci;
            sr = sa - sb - ci;
            co = (ur >= 0);
        end else begin
            ur = ua + ub + ci;
            sr = sa + sb + ci;
            co = (ur >= 64'sd4294967296);
        end
        r   = ur[31:0];
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (!FLAGS) return {r, co, 3'b000};
        return {r, co, ovf, (r == 32'd0), r[31]};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [35:0] observed();
        return {bus.result, bus.carry_out, bus.overflow, bus.zero, bus.negative};
    endfunction

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.carry_in  = 1'b0;
        bus.sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (observed() !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", observed(), 36'd0);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, input logic [35:0] exp_v);
        int lat;
        @(negedge clk);
        bus.operand1  = a;
        bus.operand2  = b;
        bus.carry_in  = cin;
        bus.sub       = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b expected 1", name, bus.in_ready);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (lat != STAGES) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, STAGES);
        end
        checks++;
        if (observed() !== exp_v) begin
            errors++;
            $display("FAIL %s_value: got %h expected %h", name, observed(), exp_v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: got out_valid %b expected 0", name, bus.out_valid);
        end
    endtask

    task automatic test_arith();
        logic f;
        f = FLAGS;
        test_single_op("wrap_add",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                       {32'h0000_0000, 1'b1, 1'b0, f, 1'b0});
        test_single_op("ovf_add",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                       {32'h8000_0000, 1'b0, f, 1'b0, f});
        test_single_op("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1,
                       {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, f});
        test_single_op("sub_cin",    32'd5, 32'd7, 1'b1, 1'b1,
                       {32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, f});
        test_single_op("sub_pos",    32'd7, 32'd5, 1'b0, 1'b1,
                       {32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});
        test_single_op("sub_ovf",    32'h8000_0000, 32'd1, 1'b0, 1'b1,
                       {32'h7FFF_FFFF, 1'b1, f, 1'b0, 1'b0});
        test_single_op("add_cin",    32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0,
                       {32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_backpressure();
        logic [31:0] a_v[6];
        logic [31:0] b_v[6];
        logic        c_v[6];
        logic        s_v[6];
        logic [35:0] held;
        logic [35:0] exp_v;
        bit          held_ok;
        bit          seen;
        int          stall;
        int          issued;
        int          got;
        int          stalled_cycles;
        for (int i = 0; i < 6; i++) begin
            a_v[i] = pick_operand();
            b_v[i] = pick_operand();
            c_v[i] = 1'($urandom);
            s_v[i] = 1'($urandom);
        end
        exp_q.delete();
        issued = 0; got = 0; seen = 0; stall = 0; held_ok = 0; held = '0;
        stalled_cycles = 0;
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && !seen) begin
                seen  = 1;
                stall = 3;
            end
            bus.out_ready = (stall == 0);
            if (stall > 0) stall--;
            bus.in_valid = (issued < 6);
            if (issued < 6) begin
                bus.operand1 = a_v[issued];
                bus.operand2 = b_v[issued];
                bus.carry_in = c_v[issued];
                bus.sub      = s_v[issued];
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                stalled_cycles++;
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready);
                end
                if (held_ok) begin
                    checks++;
                    if (observed() !== held) begin
                        errors++;
                        $display("FAIL bp_hold: got %h expected %h", observed(), held);
                    end
                end
                held    = observed();
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got %h expected no output", observed());
                end else begin
                    exp_v = exp_q.pop_front();
                    if (observed() !== exp_v) begin
                        errors++;
                        $display("FAIL bp_data%0d: got %h expected %h", got, observed(), exp_v);
                    end
                end
                got++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_q.push_back(ref_model(a_v[issued], b_v[issued], c_v[issued], s_v[issued]));
                issued++;
            end
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results expected 6", got);
        end
        checks++;
        if (stalled_cycles != 3) begin
            errors++;
            $display("FAIL bp_stall_cycles: got %0d stalled cycles expected 3", stalled_cycles);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        exp_q.delete();
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.operand1 = $urandom;
            bus.operand2 = $urandom;
            bus.carry_in = 1'($urandom);
            bus.sub      = 1'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_arrival: got out_valid %b expected 1", bus.out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got out_valid %b expected 0", bus.out_valid);
        end
        checks++;
        if (observed() !== 36'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: got %h expected %h", observed(), 36'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_ghost: got out_valid %b expected 0 at cycle %0d", bus.out_valid, i);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] held;
        logic [35:0] exp_v;
        bit          held_ok;
        int          accepted;
        int          produced;
        int          cyc;
        exp_q.delete();
        accepted = 0; produced = 0; cyc = 0; held_ok = 0; held = '0;
        while (accepted < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.operand1  = pick_operand();
            bus.operand2  = pick_operand();
            bus.carry_in  = 1'($urandom);
            bus.sub       = 1'($urandom);
            #1;
            if (held_ok) begin
                checks++;
                if (bus.out_valid !== 1'b1 || observed() !== held) begin
                    errors++;
                    $display("FAIL rnd_hold: got %b/%h expected 1/%h", bus.out_valid, observed(), held);
                end
            end
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready: got %b expected %b", bus.in_ready,
                         (!bus.out_valid || bus.out_ready));
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                held_ok = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got %h expected no output", observed());
                end else begin
                    exp_v = exp_q.pop_front();
                    if (observed() !== exp_v) begin
                        errors++;
                        $display("FAIL rnd_data%0d: got %h expected %h", produced, observed(), exp_v);
                    end
                end
                produced++;
            end else if (bus.out_valid === 1'b1) begin
                held    = observed();
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_q.push_back(ref_model(bus.operand1, bus.operand2, bus.carry_in, bus.sub));
                accepted++;
            end
        end
        checks++;
        if (accepted != 10000) begin
            errors++;
            $display("FAIL rnd_timeout: got %0d accepted expected 10000", accepted);
        end
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                exp_v = exp_q.pop_front();
                if (observed() !== exp_v) begin
                    errors++;
                    $display("FAIL rnd_drain%0d: got %h expected %h", produced, observed(), exp_v);
                end
                produced++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_lost: got %0d results missing expected 0", exp_q.size());
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_trailing: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined two-operand adder/subtractor; the registered, handshaked successor of the 8-bit combinational adder.
- Carry chain split into CHUNK-bit slices, one slice per pipeline stage; sustains one operation per clock at any WIDTH.
- valid/ready handshake on both sides with full backpressure.
- Feeds the datapath ALU and accumulator experiments.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by CHUNK.
CHUNK, 8, bits added per stage; STAGES = WIDTH/CHUNK (elaboration error otherwise, and if CHUNK < 1).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block accepts operation this cycle
operand1  in  WIDTH  first operand
operand2  in  WIDTH  second operand
carry_in  in  1  carry (add) / borrow (sub) input
sub  in  1  0: add, 1: subtract
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  sum/difference
carry_out  out  1  carry out of MSB (sub: 1 = no borrow)
overflow  out  1  signed overflow (flag feature)
zero  out  1  result == 0 (flag feature)
negative  out  1  result MSB (flag feature)

Behaviour:
- Reset: one clock and reset, asynchronous and active-low, ports clk and rst_n. rst_n low clears every stage valid bit, so out_valid=0. result, carry_out, overflow, zero and negative are 0. No reset-release sequencing.
- Reset mid-operation: all in-flight operations are discarded and never appear on the output.
- Effective operands: b_eff = sub ? ~operand2 : operand2; c_eff = carry_in ^ sub.
  - sub=1, carry_in=0 gives operand1 - operand2.
  - sub=1, carry_in=1 gives operand1 - operand2 - 1.
- Accept: an operation is accepted when in_valid && in_ready.
- Stall: in_ready = !out_valid || out_ready. The pipeline advances only when in_ready=1 and holds all stage registers otherwise. in_ready is combinational from out_ready.
- Stage k (0..STAGES-1):
  - Adds slice k of operand1 and b_eff plus the carry registered from stage k-1 (c_eff for k=0).
  - Registers the slice sum and the carry.
  - Higher slices travel skewed and unadded; lower result slices are carried forward.
  - Stage sub bit and MSB operands are kept for the overflow calculation.
- Latency: exactly STAGES cycles from acceptance to out_valid when unstalled. STAGES=1 gives a 1-cycle registered adder.
- Throughput: one operation per cycle.
- Ordering and bubbles: bubbles (in_valid=0) propagate as invalid stages. Results leave in acceptance order; none are lost or duplicated under any out_ready pattern.
- Output hold: while out_valid && !out_ready, result and all flags stay stable.
- carry_out is the raw carry from the last stage.
- overflow = (a_msb == b_eff_msb) && (result_msb != a_msb).
- Arithmetic is modulo 2^WIDTH; wrap-around is not an error.

Optional Feature:
ADDER_PIPE_FLAGS_EN
- Defined: overflow, zero and negative are computed as above and registered with the final stage.
- Undefined: these three outputs are tied to 0 and the MSB/sub tracking registers are not built. result, carry_out and the handshake are unchanged.

Decomposition:
- Package adder_pipe_pkg holds localparam helpers (STAGES computation, slice index function) and an op typedef {sub, carry_in}.
- Sub-module adder_pipe_stage: one CHUNK-bit slice adder plus its carry/valid/enable register, instantiated STAGES times in a generate loop.
- Skew and deskew shift registers live in the top module.

Test Plan (WIDTH=32, CHUNK=8):
1. 0xFFFFFFFF + 0x00000001, cin=0, sub=0 -> after exactly 4 cycles: result=0x00000000, carry_out=1, zero=1, overflow=0.
2. 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, negative=1, carry_out=0. With the macro undefined: overflow=negative=0, result identical.
3. sub=1: 5 - 7, cin=0 -> result=0xFFFFFFFE, carry_out=0, negative=1. Same with cin=1 -> 0xFFFFFFFD.
4. Backpressure: issue 6 back-to-back ops; hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during the stall, output stable, all 6 results in order, none lost.
5. Reset mid-flight: accept 3 ops, pull rst_n low asynchronously between clock edges -> out_valid=0 immediately; none of the 3 results ever emerge after release.
6. Random: 10,000 random operand1/operand2/cin/sub with random in_valid/out_ready -> every result and flag matches the behavioural model, in order.
